branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Branch prediction and redirect controller for the pipelined RV32 core.
- Predicts next PC at fetch using a direct-mapped BTB with 2-bit saturating counters.
- Resolves branches and jumps in EX using the branch-comparator result, then trains the predictor.
- On misprediction, sequences a one-cycle redirect plus IF/ID/EX flush, and keeps branch and mispredict statistics.

Parameters:
- INDEX_W, 6, log2 of BTB entries (64 entries).
- XLEN, 32, PC and target width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pred_en  in  1  1 = dynamic prediction; 0 = static not-taken.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc (combinational).
- pred_target  out  XLEN  predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  valid instruction in EX.
- ex_is_branch  in  1  conditional branch in EX.
- ex_is_jump  in  1  JAL/JALR in EX.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- ex_cond  in  1  branch-comparator outcome.
- ex_target  in  XLEN  computed branch/jump target.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  correct next PC.
- flush_if  out  1  kill IF/ID register.
- flush_id  out  1  kill ID/EX register.
- flush_ex  out  1  kill EX/MEM register.
- branch_cnt  out  CNT_W  resolved branches and jumps.
- mispred_cnt  out  CNT_W  mispredictions.

Behaviour:
- **Storage (per entry):**
  - valid, tag = pc[XLEN-1:INDEX_W+2], target, is_jump, ctr[1:0].
  - Index = pc[INDEX_W+1:2].
- **Reset (async, rst_n=0):**
  - All valid=0, ctr=2'b01, FSM=IDLE, counters=0.
  - redirect_valid/flush_*=0, redirect_pc=0.
  - Reset mid-redirect aborts the redirect immediately.
- **Lookup (combinational):**
  - hit = valid && tag match.
  - pred_taken = pred_en && hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4, modulo 2^XLEN.
- **Resolve:**
  - A resolve event is ex_valid && (ex_is_branch || ex_is_jump) && state==IDLE.
  - actual_taken = ex_is_jump || ex_cond.
  - actual_next = actual_taken ? ex_target : ex_pc+4.
  - mispredict = (ex_pred_taken != actual_taken) || (actual_taken && ex_pred_target != ex_target).
  - If ex_is_branch and ex_is_jump are both set, treat the instruction as a jump.
- **Training (on resolve, next edge):**
  - Branch taken: ctr saturating increment, max 3.
  - Branch not taken: ctr saturating decrement, min 0.
  - Branch taken, entry missing or tag mismatch: allocate with valid=1, tag, target=ex_target, is_jump=0, ctr=2'b10.
  - Branch not taken, entry missing: no allocation.
  - Jump: always write valid=1, tag, target=ex_target, is_jump=1, ctr=2'b11.
  - Training happens regardless of pred_en.
  - Same-cycle lookup and train of one index: lookup returns the pre-update value (no bypass).
- **Statistics:**
  - branch_cnt += 1 per resolve event.
  - mispred_cnt += 1 per mispredict.
  - Both wrap at 2^CNT_W.
- **FSM (IDLE, REDIRECT):**
  - IDLE, resolve with mispredict: register redirect_pc = actual_next and go to REDIRECT.
  - REDIRECT lasts exactly 1 cycle:
    - redirect_valid = flush_if = flush_id = flush_ex = 1.
    - ex_valid is ignored, since the EX instruction is wrong-path: no training, no count, no new mispredict.
  - REDIRECT always returns to IDLE.
  - Latency: mispredict detected in cycle N gives redirect in cycle N+1. The next resolve is accepted in N+2.
  - Back-to-back mispredicts are therefore impossible.
  - In IDLE all redirect/flush outputs are 0. redirect_pc holds its last value.

Test Plan:
- **Reset, then lookup:** reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104, counters 0.
- **Branch allocation and saturation:**
  - Resolve branch ex_pc=0x100, ex_cond=1, ex_target=0x80, ex_pred_taken=0 → next cycle redirect_valid=1, redirect_pc=0x80, all flush=1, mispred_cnt=1.
  - Lookup 0x100 → pred_taken=1, pred_target=0x80.
  - Two further taken resolves → ctr saturates at 3.
- **Hysteresis:**
  - With ctr=3, one not-taken resolve with correct ex_pred_taken=1 → mispredict; redirect_pc=0x104; ctr=2; lookup 0x100 still predicts taken.
  - A second not-taken resolve → ctr=1, predicts not-taken.
- **Jump and pred_en:**
  - JAL at 0x200 → target 0x400 trained; pred_en=1 lookup gives 0x400.
  - pred_en=0 lookup gives pred_taken=0, pred_target=0x204.
- **Wrong-path suppression:**
  - Mispredict in cycle N, and in cycle N+1 ex_valid=1 with a mispredicting branch → ignored: counts unchanged, no second redirect, no BTB write.
  - A correctly predicted branch in N+2 → branch_cnt increments, no redirect.
- **Aliasing and reset mid-op:**
  - 0x100 and 0x200+0x100 (same index, different tag) → tag mismatch gives pred_taken=0.
  - Assert rst_n=0 during REDIRECT → outputs drop to 0 immediately, BTB invalid.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//   Fetch-side next-PC prediction plus EX-side branch resolution for the RV32
//   pipeline. A direct-mapped BTB holds one entry per index, and each entry
//   carries a 2-bit saturating direction counter. When a prediction turns out
//   wrong, the block issues a one-cycle redirect together with an IF/ID/EX
//   flush.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   pred_en                        1 = dynamic prediction, 0 = static not-taken
//   if_pc                          fetch PC to look up
//   pred_taken, pred_target        combinational prediction for if_pc
//   ex_valid, ex_is_branch,
//   ex_is_jump, ex_pc              EX instruction qualifiers
//   ex_pred_taken, ex_pred_target  prediction carried down the pipe
//   ex_cond, ex_target             comparator outcome and computed target
//   redirect_valid, redirect_pc    one-cycle redirect pulse and correct PC
//   flush_if, flush_id, flush_ex   pipeline-register kills
//   branch_cnt, mispred_cnt        resolve and mispredict statistics
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int INDEX_W = 6,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_en,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    input  logic             ex_cond,
    input  logic [XLEN-1:0]  ex_target,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = XLEN - INDEX_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic             isJump;
        logic [1:0]       ctr;
    } btbEntry_t;

    typedef enum logic {IDLE, REDIRECT} state_t;

    logic [ENTRIES-1:0] btbValid;
    btbEntry_t          btb [ENTRIES];
    state_t             state;

    // ---------------- fetch lookup ----------------
    logic [INDEX_W-1:0] ifIdx;
    logic [TAG_W-1:0]   ifTag;
    btbEntry_t          lookEnt;
    logic               ifHit;

    assign ifIdx   = if_pc[INDEX_W+1:2];
    assign ifTag   = if_pc[XLEN-1:INDEX_W+2];
    assign lookEnt = btb[ifIdx];
    assign ifHit   = btbValid[ifIdx] && (lookEnt.tag == ifTag);

    assign pred_taken  = pred_en && ifHit && (lookEnt.isJump || lookEnt.ctr[1]);
    assign pred_target = pred_taken ? lookEnt.target : if_pc + XLEN'(4);

    // ---------------- EX resolve ----------------
    logic [INDEX_W-1:0] exIdx;
    logic [TAG_W-1:0]   exTag;
    logic               exHit;
    logic               resolveEv;
    logic               actualTaken;
    logic [XLEN-1:0]    actualNext;
    logic               mispredict;

    assign exIdx = ex_pc[INDEX_W+1:2];
    assign exTag = ex_pc[XLEN-1:INDEX_W+2];
    assign exHit = btbValid[exIdx] && (btb[exIdx].tag == exTag);

    // While redirecting, the EX instruction is wrong-path and gets ignored.
    assign resolveEv   = ex_valid && (ex_is_branch || ex_is_jump) && (state == IDLE);
    // A jump wins when both type flags are set.
    assign actualTaken = ex_is_jump || ex_cond;
    assign actualNext  = actualTaken ? ex_target : ex_pc + XLEN'(4);
    assign mispredict  = (ex_pred_taken != actualTaken) ||
                         (actualTaken && (ex_pred_target != ex_target));

    // ---------------- BTB training ----------------
    // The write lands on the next edge, so a lookup of the same index in the
    // resolve cycle still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btbValid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '{tag: '0, target: '0, isJump: 1'b0, ctr: 2'b01};
            end
        end else if (resolveEv) begin
            if (ex_is_jump) begin
                btbValid[exIdx] <= 1'b1;
                btb[exIdx]      <= '{tag: exTag, target: ex_target, isJump: 1'b1, ctr: 2'b11};
            end else if (exHit) begin
                if (ex_cond && btb[exIdx].ctr != 2'b11)
                    btb[exIdx].ctr <= btb[exIdx].ctr + 2'b01;
                else if (!ex_cond && btb[exIdx].ctr != 2'b00)
                    btb[exIdx].ctr <= btb[exIdx].ctr - 2'b01;
            end else if (ex_cond) begin
                // Only taken branches are worth an entry; not-taken matches fall-through.
                btbValid[exIdx] <= 1'b1;
                btb[exIdx]      <= '{tag: exTag, target: ex_target, isJump: 1'b0, ctr: 2'b10};
            end
        end
    end

    // ---------------- redirect FSM + statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            flush_ex       <= 1'b0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            // Flush outputs are registered and high only during the REDIRECT cycle.
            redirect_valid <= 1'b0;
            flush_if       <= 1'b0;
            flush_id       <= 1'b0;
            flush_ex       <= 1'b0;
            if (resolveEv)
                branch_cnt <= branch_cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (resolveEv && mispredict) begin
                        state          <= REDIRECT;
                        mispred_cnt    <= mispred_cnt + CNT_W'(1);
                        redirect_pc    <= actualNext;
                        redirect_valid <= 1'b1;
                        flush_if       <= 1'b1;
                        flush_id       <= 1'b1;
                        flush_ex       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_en;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_cond;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if, flush_id, flush_ex;
    logic [31:0] branch_cnt, mispred_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.INDEX_W(6), .XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pred_en(pred_en), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_cond(ex_cond), .ex_target(ex_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Registered redirect/flush outputs, all expected equal to v.
    task automatic chkRedir(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, v});
        chk({tag, ".flush"}, {29'd0, flush_if, flush_id, flush_ex}, v ? 32'd7 : 32'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, pc);
    endtask

    task automatic chkCnt(input string tag, input int bc, input int mp);
        chk({tag, ".branch_cnt"}, branch_cnt, bc);
        chk({tag, ".mispred_cnt"}, mispred_cnt, mp);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt);
        if_pc = pc;
        #1;
        chk({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".pred_target"}, pred_target, tgt);
    endtask

    task automatic exDrive(input logic br, input logic jmp, input logic [31:0] pc,
                           input logic cond, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_pc = pc;
        ex_cond = cond; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    initial begin
        rst_n = 1'b0; pred_en = 1'b1; if_pc = 32'h100;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_pc = '0;
        ex_cond = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        lookup("rst", 32'h100, 1'b0, 32'h104);
        chkRedir("rst", 1'b0, 32'h0);
        chkCnt("rst", 0, 0);
        rst_n = 1'b1;

        // Taken branch at 0x100, predicted not-taken: allocate, mispredict
        @(negedge clk);
        exDrive(1, 0, 32'h100, 1, 32'h80, 0, 32'h104);
        @(negedge clk);
        chkRedir("alloc", 1'b1, 32'h80);
        chkCnt("alloc", 1, 1);
        ex_valid = 1'b0;
        lookup("alloc", 32'h100, 1'b1, 32'h80);
        @(negedge clk);
        chkRedir("alloc_end", 1'b0, 32'h80);

        // Two correctly predicted taken resolves: ctr 2->3->3
        exDrive(1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
        @(negedge clk);
        chkRedir("tk2", 1'b0, 32'h80);
        chkCnt("tk2", 2, 1);
        @(negedge clk);
        chkCnt("tk3", 3, 1);
        lookup("tk3", 32'h100, 1'b1, 32'h80);

        // Hysteresis: not-taken from ctr=3 still predicts taken
        exDrive(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
        @(negedge clk);
        chkRedir("nt1", 1'b1, 32'h104);
        chkCnt("nt1", 4, 2);
        ex_valid = 1'b0;
        lookup("nt1", 32'h100, 1'b1, 32'h80);
        @(negedge clk);
        exDrive(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
        @(negedge clk);
        chkRedir("nt2", 1'b1, 32'h104);
        chkCnt("nt2", 5, 3);
        ex_valid = 1'b0;
        lookup("nt2", 32'h100, 1'b0, 32'h104);

        // JAL at 0x200 (same index as 0x100), target 0x400
        @(negedge clk);
        exDrive(0, 1, 32'h200, 0, 32'h400, 0, 32'h204);
        @(negedge clk);
        chkRedir("jal", 1'b1, 32'h400);
        chkCnt("jal", 6, 4);
        ex_valid = 1'b0;
        lookup("jal", 32'h200, 1'b1, 32'h400);
        pred_en = 1'b0;
        lookup("jal_static", 32'h200, 1'b0, 32'h204);
        pred_en = 1'b1;
        @(negedge clk);
        lookup("alias100", 32'h100, 1'b0, 32'h104);
        lookup("alias300", 32'h300, 1'b0, 32'h304);

        // Wrong-path suppression: mispredict at N, mispredicting branch at N+1
        exDrive(1, 0, 32'h300, 1, 32'h500, 0, 32'h304);
        @(negedge clk);
        chkRedir("wp_n1", 1'b1, 32'h500);
        chkCnt("wp_n1", 7, 5);
        exDrive(1, 0, 32'h104, 1, 32'h600, 0, 32'h108);
        @(negedge clk);
        chkRedir("wp_n2", 1'b0, 32'h500);
        chkCnt("wp_n2", 7, 5);
        lookup("wp_nowrite", 32'h104, 1'b0, 32'h108);
        lookup("wp_alloc", 32'h300, 1'b1, 32'h500);
        // Correctly predicted branch at N+2 is accepted
        exDrive(1, 0, 32'h300, 1, 32'h500, 1, 32'h500);
        @(negedge clk);
        chkRedir("wp_n3", 1'b0, 32'h500);
        chkCnt("wp_n3", 8, 5);

        // Not-taken branch with no entry: correct, no allocation
        exDrive(1, 0, 32'h108, 0, 32'h700, 0, 32'h10c);
        @(negedge clk);
        chkRedir("ntmiss", 1'b0, 32'h500);
        chkCnt("ntmiss", 9, 5);
        ex_valid = 1'b0;
        lookup("ntmiss", 32'h108, 1'b0, 32'h10c);

        // Reset during REDIRECT
        @(negedge clk);
        exDrive(1, 0, 32'h300, 0, 32'h500, 1, 32'h500);
        @(negedge clk);
        chkRedir("pre_rst", 1'b1, 32'h304);
        chkCnt("pre_rst", 10, 6);
        ex_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chkRedir("mid_rst", 1'b0, 32'h0);
        chkCnt("mid_rst", 0, 0);
        lookup("mid_rst300", 32'h300, 1'b0, 32'h304);
        lookup("mid_rst200", 32'h200, 1'b0, 32'h204);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chkRedir("post_rst", 1'b0, 32'h0);
        lookup("post_rst", 32'h300, 1'b0, 32'h304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
